// File: rtl/led_pattern_sched_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// The control word layout matches the GPIO blink-LED driver: [31:30] mode, [29:0] half-period / 4.
package led_pattern_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_e;

  localparam logic [1:0]  LED_OFF        = 2'b00;
  localparam logic [1:0]  LED_ON         = 2'b11;
  localparam logic [31:0] CTRL_OFF       = {LED_OFF, 30'h0};
  localparam int          TICK_DIV_33MHZ = 33000;

endpackage

// File: rtl/led_pattern_sched_prescaler.sv
// Duration-tick prescaler: counts 0..TICK_DIV-1 while enabled, tick on the last count.
// clr has priority over en so a step load always restarts a full tick period.
module led_tick_prescaler #(
  parameter int TICK_DIV = 33000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == PW'(TICK_DIV - 1));
  assign tick   = en && at_top;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_top ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_sched.sv
// Steps one LED driver's control word through a programmable (word, duration) table,
// with a level override that pre-empts the table and lets the sequence resume afterwards.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no sequence; control = off, or ovr_ctrl while ovr_valid
//   ST_RUN  | showing table entry step_idx, duration countdown active
//   ST_HOLD | override shown, countdown frozen, step_idx is resume point
module led_pattern_sched
  import led_pattern_sched_pkg::*;
#(
  parameter  int STEPS    = 8,
  parameter  int TICK_DIV = TICK_DIV_33MHZ,
  parameter  int DUR_W    = 16,
  localparam int AW       = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [31:0]      cfg_ctrl,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic             cfg_last,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  input  logic             ovr_valid,
  input  logic [31:0]      ovr_ctrl,
  output logic [31:0]      control,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             done
);

  // table storage is deliberately not reset
  logic [31:0]      tbl_ctrl_q [STEPS];
  logic [31:0]      tbl_ctrl_d [STEPS];
  logic [DUR_W-1:0] tbl_dur_q  [STEPS];
  logic [DUR_W-1:0] tbl_dur_d  [STEPS];
  logic [STEPS-1:0] tbl_last_q, tbl_last_d;

  always_comb begin
    tbl_ctrl_d = tbl_ctrl_q;
    tbl_dur_d  = tbl_dur_q;
    tbl_last_d = tbl_last_q;
    if (cfg_we) begin
      tbl_ctrl_d[cfg_addr] = cfg_ctrl;
      tbl_dur_d[cfg_addr]  = cfg_dur;
      tbl_last_d[cfg_addr] = cfg_last;
    end
  end

  always_ff @(posedge clk) begin
    tbl_ctrl_q <= tbl_ctrl_d;
    tbl_dur_q  <= tbl_dur_d;
    tbl_last_q <= tbl_last_d;
  end

  sched_state_e     state_q, state_d;
  logic [31:0]      control_q, control_d;
  logic [AW-1:0]    step_q, step_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             presc_clr, presc_en, tick;
  logic             load_en;
  logic [AW-1:0]    load_idx;

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    control_d = control_q;
    step_d    = step_q;
    dur_d     = dur_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;
    presc_en  = 1'b0;
    load_en   = 1'b0;
    load_idx  = '0;

    if (stop) begin
      done_d    = (state_q != ST_IDLE);
      state_d   = ST_IDLE;
      control_d = ovr_valid ? ovr_ctrl : CTRL_OFF;
      step_d    = '0;
      dur_d     = '0;
      presc_clr = 1'b1;
    end else if (start) begin
      state_d   = ovr_valid ? ST_HOLD : ST_RUN;
      control_d = ovr_ctrl;
      load_en   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: control_d = ovr_valid ? ovr_ctrl : CTRL_OFF;
        ST_RUN, ST_HOLD: begin
          if (ovr_valid) begin
            state_d   = ST_HOLD;
            control_d = ovr_ctrl;
          end else begin
            state_d = ST_RUN;
            // the release edge counts as a run cycle so the override does not
            // steal display time from the entry
            if (state_q == ST_HOLD) control_d = tbl_ctrl_q[step_q];
            if (dur_q != '0) begin
              presc_en = 1'b1;
              if (tick) begin
                if (dur_q == DUR_W'(1)) begin
                  if (tbl_last_q[step_q] || (step_q == AW'(STEPS - 1))) begin
                    if (loop_en) begin
                      load_en = 1'b1;
                    end else begin
                      state_d   = ST_IDLE;
                      control_d = CTRL_OFF;
                      done_d    = 1'b1;
                      step_d    = '0;
                      dur_d     = '0;
                      presc_clr = 1'b1;
                    end
                  end else begin
                    load_en  = 1'b1;
                    load_idx = step_q + AW'(1);
                  end
                end else begin
                  dur_d = dur_q - DUR_W'(1);
                end
              end
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          control_d = CTRL_OFF;
        end
      endcase
    end

    // loads read the registered table, so a same-cycle write is not seen
    if (load_en) begin
      step_d    = load_idx;
      dur_d     = tbl_dur_q[load_idx];
      presc_clr = 1'b1;
      if (state_d == ST_RUN) control_d = tbl_ctrl_q[load_idx];
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      control_q <= CTRL_OFF;
      step_q    <= '0;
      dur_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      control_q <= control_d;
      step_q    <= step_d;
      dur_q     <= dur_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign control  = control_q;
  assign busy     = busy_q;
  assign step_idx = step_q;
  assign done     = done_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched with TICK_DIV=4, STEPS=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_led_pattern_sched;

  localparam int STEPS    = 8;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 16;
  localparam int AW       = 3;

  logic             clk;
  logic             reset;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [31:0]      cfg_ctrl;
  logic [DUR_W-1:0] cfg_dur;
  logic             cfg_last;
  logic             loop_en;
  logic             start;
  logic             stop;
  logic             ovr_valid;
  logic [31:0]      ovr_ctrl;
  logic [31:0]      control;
  logic             busy;
  logic [AW-1:0]    step_idx;
  logic             done;

  int n_chk  = 0;
  int n_fail = 0;

  led_pattern_sched #(
    .STEPS    (STEPS),
    .TICK_DIV (TICK_DIV),
    .DUR_W    (DUR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_ctrl  (cfg_ctrl),
    .cfg_dur   (cfg_dur),
    .cfg_last  (cfg_last),
    .loop_en   (loop_en),
    .start     (start),
    .stop      (stop),
    .ovr_valid (ovr_valid),
    .ovr_ctrl  (ovr_ctrl),
    .control   (control),
    .busy      (busy),
    .step_idx  (step_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] c, input int d, input logic l);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_ctrl = c;
    cfg_dur  = 16'(d);
    cfg_last = l;
    cyc(1);
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_ctrl = '0; cfg_dur = '0; cfg_last = 1'b0;
    loop_en = 1'b0; start = 1'b0; stop = 1'b0; ovr_valid = 1'b0; ovr_ctrl = '0;
    cyc(2);
    chk("rst_control", control, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_step", {29'd0, step_idx}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    wr(0, 32'hC000_0010, 2, 1'b0);
    wr(1, 32'hFFFF_FFFF, 1, 1'b1);

    // reset in the middle of a run, then immediate restart
    pulse_start();
    cyc(5);
    chk("t1_running", control, 32'hC000_0010);
    reset = 1'b1;
    cyc(1);
    chk("t1_rst_control", control, 32'h0);
    chk("t1_rst_busy", {31'd0, busy}, 32'd0);
    chk("t1_rst_step", {29'd0, step_idx}, 32'd0);
    reset = 1'b0;
    pulse_start();
    chk("t1_restart_control", control, 32'hC000_0010);
    chk("t1_restart_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t1_stop_done", {31'd0, done}, 32'd1);
    cyc(2);

    // one-shot two-entry sequence
    loop_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      chk("t2_entry0", control, 32'hC000_0010);
      chk("t2_step0", {29'd0, step_idx}, 32'd0);
      chk("t2_nodone0", {31'd0, done}, 32'd0);
      cyc(1);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t2_entry1", control, 32'hFFFF_FFFF);
      chk("t2_step1", {29'd0, step_idx}, 32'd1);
      chk("t2_busy1", {31'd0, busy}, 32'd1);
      cyc(1);
    end
    chk("t2_end_control", control, 32'h0);
    chk("t2_end_done", {31'd0, done}, 32'd1);
    chk("t2_end_busy", {31'd0, busy}, 32'd0);
    cyc(1);
    chk("t2_done_single", {31'd0, done}, 32'd0);
    cyc(3);
    chk("t2_idle_control", control, 32'h0);

    // looping, then stop
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      chk("t3_loop_word", control, ((i % 12) < 8) ? 32'hC000_0010 : 32'hFFFF_FFFF);
      chk("t3_no_done", {31'd0, done}, 32'd0);
      cyc(1);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t3_stop_control", control, 32'h0);
    chk("t3_stop_done", {31'd0, done}, 32'd1);
    chk("t3_stop_busy", {31'd0, busy}, 32'd0);
    cyc(1);
    chk("t3_done_cleared", {31'd0, done}, 32'd0);
    cyc(2);

    // 5-cycle override during entry 0; entry 0 still shown 8 cycles in total
    loop_en = 1'b0;
    ovr_ctrl = 32'h4000_0123;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      chk("t4_pre_ovr", control, 32'hC000_0010);
      if (i == 2) ovr_valid = 1'b1;
      cyc(1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_ovr_word", control, 32'h4000_0123);
      chk("t4_ovr_busy", {31'd0, busy}, 32'd1);
      if (i == 4) ovr_valid = 1'b0;
      cyc(1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_resume", control, 32'hC000_0010);
      chk("t4_resume_step", {29'd0, step_idx}, 32'd0);
      cyc(1);
    end
    chk("t4_next_entry", control, 32'hFFFF_FFFF);
    cyc(4);
    chk("t4_end_control", control, 32'h0);
    chk("t4_end_done", {31'd0, done}, 32'd1);
    // override in IDLE shows the word but does not make the block busy
    ovr_valid = 1'b1;
    cyc(1);
    chk("t4_idle_ovr", control, 32'h4000_0123);
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    ovr_valid = 1'b0;
    cyc(1);
    chk("t4_idle_release", control, 32'h0);

    // start+stop together in RUN; then a hold-forever entry
    pulse_start();
    cyc(2);
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_ss_control", control, 32'h0);
    chk("t5_ss_done", {31'd0, done}, 32'd1);
    chk("t5_ss_busy", {31'd0, busy}, 32'd0);
    wr(0, 32'h8000_0002, 0, 1'b0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      cyc(30);
      chk("t5_hold_control", control, 32'h8000_0002);
      chk("t5_hold_step", {29'd0, step_idx}, 32'd0);
      chk("t5_hold_busy", {31'd0, busy}, 32'd1);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t5_hold_stop_done", {31'd0, done}, 32'd1);
    cyc(1);

    // eight entries, none marked last: wrap from 7 to 0, with entry 0 rewritten mid-run
    for (int k = 0; k < 8; k++) wr(k, 32'h8000_0010 + 32'(k), 1, 1'b0);
    loop_en = 1'b1;
    pulse_start();
    for (int s = 0; s < 36; s++) begin
      if ((s % 4) == 0 || (s % 4) == 3) begin
        chk("t6_word", control, (s >= 32) ? 32'hC000_00AA : 32'h8000_0010 + 32'((s / 4) % 8));
        chk("t6_step", {29'd0, step_idx}, 32'((s / 4) % 8));
      end
      if (s == 13) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_ctrl = 32'hC000_00AA; cfg_dur = 16'd1; cfg_last = 1'b0;
      end else begin
        cfg_we = 1'b0;
      end
      cyc(1);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t6_stop_control", control, 32'h0);
    chk("t6_stop_done", {31'd0, done}, 32'd1);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
